// File: rtl/sat_pkg.sv
// Shared helpers for the multi-channel saturation block: wide signed clamp,
// sign extension and counter ceiling. Wide math is done in W_MAX bits.
package sat_pkg;

    localparam int W_MAX     = 64;
    localparam int DEF_N_BIT = 32;
    localparam int DZ_BIT    = DEF_N_BIT + 1;

    typedef logic signed [W_MAX-1:0] wide_t;

    function automatic wide_t clamp(
        input wide_t x,
        input wide_t lo,
        input wide_t hi
    );
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Sign-extend the low n bits of x to W_MAX; callers keep N_BIT+1 of it.
    function automatic wide_t sext(
        input logic [W_MAX-1:0] x,
        input int               n
    );
        wide_t r;
        for (int i = 0; i < W_MAX; i++) begin
            r[i] = (i < n) ? x[i] : x[n-1];
        end
        return r;
    endfunction

    function automatic logic [W_MAX-1:0] cnt_max(input int n);
        return {W_MAX{1'b1}} >> (W_MAX - n);
    endfunction

endpackage

// File: rtl/sat_channel.sv
// One channel of stage 2: clamp select, dead-zone, flags, event counter.
// Rate limiter present when SATURATION_MULTI_RATE_LIMIT_EN is defined.
module sat_channel
    import sat_pkg::*;
#(
    parameter int     N_BIT     = DEF_N_BIT,
    parameter int     DZ_W      = DZ_BIT,
    parameter int     CNT_BIT   = 16,
    parameter int     RATE_STEP = 8,
    parameter longint PREV_INIT = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [N_BIT-1:0] u,
    input  logic signed [N_BIT-1:0] lim_hi,
    input  logic signed [N_BIT-1:0] lim_lo,
    input  logic                    gt,
    input  logic                    lt,
    input  logic                    cnt_clear,
    input  logic                    ld_ok,
    input  logic signed [N_BIT-1:0] ld_hi,
    input  logic signed [N_BIT-1:0] ld_lo,
    output logic signed [N_BIT-1:0] u_sat,
    output logic signed [DZ_W-1:0]  u_dz,
    output logic                    sat_hi,
    output logic                    sat_lo,
    output logic [CNT_BIT-1:0]      sat_cnt,
    output logic                    rate_act
);

    localparam logic [W_MAX-1:0]   CMAX_W = cnt_max(CNT_BIT);
    localparam logic [CNT_BIT-1:0] CMAX   = CMAX_W[CNT_BIT-1:0];

    wide_t u_w;
    wide_t hi_w;
    wide_t lo_w;
    wide_t tgt_w;
    wide_t out_w;
    wide_t dz_w;

    assign u_w   = sext(W_MAX'(u), N_BIT);
    assign hi_w  = sext(W_MAX'(lim_hi), N_BIT);
    assign lo_w  = sext(W_MAX'(lim_lo), N_BIT);
    assign tgt_w = gt ? hi_w : (lt ? lo_w : u_w);
    assign dz_w  = u_w - out_w;

`ifdef SATURATION_MULTI_RATE_LIMIT_EN
    localparam logic signed [N_BIT-1:0] PREV_RST = N_BIT'(PREV_INIT);
    localparam wide_t STEP_HI = wide_t'(RATE_STEP);
    localparam wide_t STEP_LO = -STEP_HI;

    logic signed [N_BIT-1:0] prev;
    wide_t prev_w;
    wide_t delta_w;
    wide_t step_w;
    wide_t nxt_w;
    wide_t clip_w;
    logic  ract;
    logic  unused_rate;

    assign prev_w  = sext(W_MAX'(prev), N_BIT);
    assign delta_w = tgt_w - prev_w;
    assign step_w  = clamp(delta_w, STEP_LO, STEP_HI);
    assign out_w   = prev_w + step_w;
    assign ract    = (step_w != delta_w);
    assign nxt_w   = en ? out_w : prev_w;
    assign clip_w  = clamp(nxt_w,
                           sext(W_MAX'(ld_lo), N_BIT),
                           sext(W_MAX'(ld_hi), N_BIT));
    assign unused_rate = ^clip_w[W_MAX-1:N_BIT];

    // prev follows each emitted output, pulled into newly loaded limits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev <= PREV_RST;
        end else if (ld_ok) begin
            prev <= clip_w[N_BIT-1:0];
        end else if (en) begin
            prev <= out_w[N_BIT-1:0];
        end
    end

    // step-limited flag travels with the emitted result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rate_act <= 1'b0;
        end else if (en) begin
            rate_act <= ract;
        end
    end
`else
    logic unused_rate;

    assign out_w       = tgt_w;
    assign rate_act    = 1'b0;
    assign unused_rate = ^{ld_ok, ld_hi, ld_lo};
`endif

    logic unused_hi;
    assign unused_hi = ^dz_w[W_MAX-1:DZ_W];

    // result registers hold their value between emitted samples
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            u_sat  <= '0;
            u_dz   <= '0;
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
        end else if (en) begin
            u_sat  <= out_w[N_BIT-1:0];
            u_dz   <= dz_w[DZ_W-1:0];
            sat_hi <= gt;
            sat_lo <= lt;
        end
    end

    // event counter: clear beats increment, sticks at the ceiling
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_cnt <= '0;
        end else if (cnt_clear) begin
            sat_cnt <= '0;
        end else if (en && (gt || lt) && (sat_cnt != CMAX)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/saturation_multi.sv
// Pipelined multi-channel signed saturation, 2-cycle latency, loadable limits.
// Optional rate limiter: define SATURATION_MULTI_RATE_LIMIT_EN.
module saturation_multi
    import sat_pkg::*;
#(
    parameter int     N_BIT       = DEF_N_BIT,
    parameter int     N_CH        = 4,
    parameter longint UPPER_LIMIT = 100,
    parameter longint LOWER_LIMIT = 0,
    parameter int     CNT_BIT     = 16,
    parameter int     RATE_STEP   = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [N_CH*N_BIT-1:0]       u,
    input  logic                        lim_load,
    input  logic signed [N_BIT-1:0]     lim_upper,
    input  logic signed [N_BIT-1:0]     lim_lower,
    input  logic                        cnt_clear,
    output logic                        out_valid,
    output logic [N_CH*N_BIT-1:0]       u_sat,
    output logic [N_CH*(N_BIT+1)-1:0]   u_dz,
    output logic [N_CH-1:0]             sat_hi,
    output logic [N_CH-1:0]             sat_lo,
    output logic [N_CH*CNT_BIT-1:0]     sat_cnt,
    output logic                        lim_err,
    output logic [N_CH-1:0]             rate_act
);

    localparam int DW = N_BIT + 1;
    localparam longint PREV_INIT =
        (LOWER_LIMIT > 0) ? LOWER_LIMIT :
        ((UPPER_LIMIT < 0) ? UPPER_LIMIT : 64'sd0);
    localparam logic signed [N_BIT-1:0] UP_RST = N_BIT'(UPPER_LIMIT);
    localparam logic signed [N_BIT-1:0] LO_RST = N_BIT'(LOWER_LIMIT);

    logic signed [N_BIT-1:0] lim_hi;
    logic signed [N_BIT-1:0] lim_lo;
    logic                    ld_ok;

    logic                    v1;
    logic                    v2;
    logic [N_CH*N_BIT-1:0]   u1;
    logic signed [N_BIT-1:0] hi1;
    logic signed [N_BIT-1:0] lo1;
    logic [N_CH-1:0]         gt_c;
    logic [N_CH-1:0]         lt_c;
    logic [N_CH-1:0]         gt1;
    logic [N_CH-1:0]         lt1;

    assign ld_ok     = lim_load && (lim_lower <= lim_upper);
    assign out_valid = v2;

    // active limits; a bad request leaves them and raises the sticky error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lim_hi  <= UP_RST;
            lim_lo  <= LO_RST;
            lim_err <= 1'b0;
        end else if (ld_ok) begin
            lim_hi  <= lim_upper;
            lim_lo  <= lim_lower;
            lim_err <= 1'b0;
        end else if (lim_load) begin
            lim_err <= 1'b1;
        end
    end

    // stage 1: sample, the limits it was compared against, compare results
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            u1  <= '0;
            hi1 <= UP_RST;
            lo1 <= LO_RST;
            gt1 <= '0;
            lt1 <= '0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
            if (in_valid) begin
                u1  <= u;
                hi1 <= lim_hi;
                lo1 <= lim_lo;
                gt1 <= gt_c;
                lt1 <= lt_c;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic signed [N_BIT-1:0] uk;
        logic signed [N_BIT-1:0] u1k;

        assign uk      = u[k*N_BIT +: N_BIT];
        assign u1k     = u1[k*N_BIT +: N_BIT];
        assign gt_c[k] = uk > lim_hi;
        assign lt_c[k] = uk < lim_lo;

        sat_channel #(
            .N_BIT    (N_BIT),
            .DZ_W     (DW),
            .CNT_BIT  (CNT_BIT),
            .RATE_STEP(RATE_STEP),
            .PREV_INIT(PREV_INIT)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .en       (v1),
            .u        (u1k),
            .lim_hi   (hi1),
            .lim_lo   (lo1),
            .gt       (gt1[k]),
            .lt       (lt1[k]),
            .cnt_clear(cnt_clear),
            .ld_ok    (ld_ok),
            .ld_hi    (lim_upper),
            .ld_lo    (lim_lower),
            .u_sat    (u_sat[k*N_BIT +: N_BIT]),
            .u_dz     (u_dz[k*DW +: DW]),
            .sat_hi   (sat_hi[k]),
            .sat_lo   (sat_lo[k]),
            .sat_cnt  (sat_cnt[k*CNT_BIT +: CNT_BIT]),
            .rate_act (rate_act[k])
        );
    end

endmodule

// File: tb/tb_saturation_multi.sv
// Directed bench for saturation_multi with a scoreboard of expected results.
// Build with SATURATION_MULTI_RATE_LIMIT_EN to also cover the rate limiter.
module tb_saturation_multi;

    localparam int NB = 16;
    localparam int NC = 4;
    localparam int CB = 2;
    localparam int RS = 8;

    logic                   clock;
    logic                   reset;
    logic                   in_valid;
    logic [NC*NB-1:0]       u;
    logic                   lim_load;
    logic [NB-1:0]          lim_upper;
    logic [NB-1:0]          lim_lower;
    logic                   cnt_clear;
    logic                   out_valid;
    logic [NC*NB-1:0]       u_sat;
    logic [NC*(NB+1)-1:0]   u_dz;
    logic [NC-1:0]          sat_hi;
    logic [NC-1:0]          sat_lo;
    logic [NC*CB-1:0]       sat_cnt;
    logic                   lim_err;
    logic [NC-1:0]          rate_act;

    saturation_multi #(
        .N_BIT      (NB),
        .N_CH       (NC),
        .UPPER_LIMIT(100),
        .LOWER_LIMIT(0),
        .CNT_BIT    (CB),
        .RATE_STEP  (RS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .u        (u),
        .lim_load (lim_load),
        .lim_upper(lim_upper),
        .lim_lower(lim_lower),
        .cnt_clear(cnt_clear),
        .out_valid(out_valid),
        .u_sat    (u_sat),
        .u_dz     (u_dz),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo),
        .sat_cnt  (sat_cnt),
        .lim_err  (lim_err),
        .rate_act (rate_act)
    );

    typedef struct {
        int                   cyc;
        logic [NC*NB-1:0]     sat;
        logic [NC*(NB+1)-1:0] dz;
        logic [NC-1:0]        hi;
        logic [NC-1:0]        lo;
        logic [NC-1:0]        ra;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   m_hi;
    int   m_lo;
    int   m_prev[NC];
    logic [NC*NB-1:0]     last_sat;
    logic [NC*(NB+1)-1:0] last_dz;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int x, input int lo, input int hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic drive(input bit vld, input int a, input int b,
                         input int c, input int d, input bit ld,
                         input int lo, input int hi, input bit clr);
        int   v[NC];
        int   tgt;
        int   outv;
        exp_t e;
        bit   ok;
        @(posedge clock);
        #1;
        v[0] = a;
        v[1] = b;
        v[2] = c;
        v[3] = d;
        in_valid  = vld;
        lim_load  = ld;
        lim_lower = NB'(lo);
        lim_upper = NB'(hi);
        cnt_clear = clr;
        for (int k = 0; k < NC; k++) u[k*NB +: NB] = NB'(v[k]);
        ok = ld && (lo <= hi);
        if (ok) begin
            for (int k = 0; k < NC; k++) m_prev[k] = clampi(m_prev[k], lo, hi);
        end
        if (vld) begin
            e.cyc = cyc;
            e.sat = '0;
            e.dz  = '0;
            e.hi  = '0;
            e.lo  = '0;
            e.ra  = '0;
            for (int k = 0; k < NC; k++) begin
                tgt = clampi(v[k], m_lo, m_hi);
                e.hi[k] = v[k] > m_hi;
                e.lo[k] = v[k] < m_lo;
`ifdef SATURATION_MULTI_RATE_LIMIT_EN
                outv = m_prev[k] + clampi(tgt - m_prev[k], -RS, RS);
                e.ra[k] = (outv != tgt);
                m_prev[k] = outv;
`else
                outv = tgt;
`endif
                e.sat[k*NB +: NB] = NB'(outv);
                e.dz[k*(NB+1) +: NB+1] = (NB+1)'(v[k] - outv);
            end
            q.push_back(e);
        end
        if (ok) begin
            m_lo = lo;
            m_hi = hi;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        #2;
        reset     = 1'b1;
        in_valid  = 1'b0;
        lim_load  = 1'b0;
        cnt_clear = 1'b0;
        u         = '0;
        lim_upper = '0;
        lim_lower = '0;
        q.delete();
        m_hi = 100;
        m_lo = 0;
        for (int k = 0; k < NC; k++) m_prev[k] = 0;
        last_sat = '0;
        last_dz  = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_u_sat", u_sat, 0);
        chk("rst_u_dz", u_dz, 0);
        chk("rst_flags", {sat_hi, sat_lo, rate_act, lim_err}, 0);
        chk("rst_cnt", sat_cnt, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc, e.cyc + 2);
                    chk("u_sat", u_sat, e.sat);
                    chk("u_dz", u_dz, e.dz);
                    chk("sat_hi", sat_hi, e.hi);
                    chk("sat_lo", sat_lo, e.lo);
                    chk("rate_act", rate_act, e.ra);
                    last_sat = e.sat;
                    last_dz  = e.dz;
                end
            end else begin
                chk("hold_sat", u_sat, last_sat);
                chk("hold_dz", u_dz, last_dz);
            end
        end
    end

    initial begin
        reset = 1'b1;
        do_reset();

        // basic pattern on default limits [0,100]
        drive(1, 150, 100, -3, 42, 0, 0, 0, 0);
        idle(3);
        chk("cnt_basic", sat_cnt, 8'h11);

        // extremes against [-10,10]
        drive(0, 0, 0, 0, 0, 1, -10, 10, 0);
        idle(1);
        chk("lim_err_ok", lim_err, 0);
        drive(1, -32768, 32767, 0, 10, 0, 0, 0, 0);
        idle(3);
        chk("cnt_ext", sat_cnt, 8'h16);

        // load while sampling: old limits apply to that sample
        drive(0, 0, 0, 0, 0, 1, 0, 100, 0);
        drive(1, 30, 30, 30, 30, 1, -50, 20, 0);
        drive(1, 30, 30, 30, 30, 0, 0, 0, 0);
        idle(3);
        chk("cnt_load", sat_cnt, 8'h6B);
        drive(0, 0, 0, 0, 0, 1, 5, -5, 0);
        idle(1);
        chk("lim_err_rej", lim_err, 1);
        drive(1, 30, 30, 30, 30, 0, 0, 0, 0);
        idle(3);
        chk("cnt_after_rej", sat_cnt, 8'hBF);
        chk("lim_err_sticky", lim_err, 1);
        drive(0, 0, 0, 0, 0, 1, -100, 100, 0);
        idle(1);
        chk("lim_err_clr", lim_err, 0);

        // counter ceiling and clear priority
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        chk("cnt_clear", sat_cnt, 0);
        for (int i = 0; i < 4; i++) drive(1, 150, 150, -150, 150, 0, 0, 0, 0);
        idle(3);
        chk("cnt_cap", sat_cnt, 8'hFF);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 150, 150, 150, 150, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        chk("cnt_clear_wins", sat_cnt, 0);

        // reset with samples in flight
        drive(1, 150, 150, 150, 150, 0, 0, 0, 0);
        drive(1, 150, 150, 150, 150, 0, 0, 0, 0);
        drive(1, 150, 150, 150, 150, 0, 0, 0, 0);
        do_reset();
        idle(3);
        chk("cnt_post_rst", sat_cnt, 0);
        drive(1, 150, 100, -3, 42, 0, 0, 0, 0);
        idle(3);
        chk("cnt_post_rst_smp", sat_cnt, 8'h11);

`ifdef SATURATION_MULTI_RATE_LIMIT_EN
        // ramp toward the upper limit in steps of RATE_STEP
        do_reset();
        for (int i = 0; i < 14; i++) drive(1, 150, 150, 150, 150, 0, 0, 0, 0);
        idle(3);
        chk("ramp_final", u_sat, {4{16'd100}});
`endif

        idle(2);
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
